bram_stream_reader: RTL and testbench

Streaming read engine for the single-clock dual-port block RAM's read port. On a start command it walks a contiguous address range from a base address, drives the RAM's read enable and read address, absorbs the RAM's one-cycle registered read latency, and presents the words as a valid/ready stream with full throughput under no backpressure. It sits between a buffer that some producer fills through the RAM write port and any downstream consumer that requires flow control.

---
 rtl/bram_stream_reader.sv | 127 ++++++++++++
 tb/tb_bram_stream_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Streams a contiguous address range out of a block RAM read port with one-cycle read latency.
// A 2-entry output FIFO absorbs the latency so the stream runs at one word per cycle without backpressure.
module bram_stream_reader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic                  enb,
   output logic [ADDR_WIDTH-1:0] addrb,
   input  logic [DATA_WIDTH-1:0] dob,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
   logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
   logic [ADDR_WIDTH:0]   iss_rem_q, iss_rem_d;
   logic [ADDR_WIDTH:0]   emit_rem_q, emit_rem_d;
   logic                  inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0] fifo0_q, fifo0_d;
   logic [DATA_WIDTH-1:0] fifo1_q, fifo1_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;

   logic                  pop;
   logic                  push;
   logic [2:0]            occ;
   logic                  enb_c;

   assign out_valid = (count_q != 2'd0);
   assign out_data  = rd_ptr_q ? fifo1_q : fifo0_q;
   // The head is the final word exactly when it is the only word left to emit.
   assign out_last  = out_valid && (emit_rem_q == (ADDR_WIDTH+1)'(1));
   assign pop       = out_valid && out_ready;
   assign push      = inflight_q;
   assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign enb_c     = (state_q == S_RUN) && (iss_rem_q != '0) && (occ < 3'd2);
   assign enb       = enb_c;
   assign addrb     = enb_c ? iss_addr_q : addr_hold_q;
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);

   always_comb begin
      state_d     = state_q;
      iss_addr_d  = iss_addr_q;
      addr_hold_d = addrb;
      iss_rem_d   = iss_rem_q;
      emit_rem_d  = emit_rem_q;
      inflight_d  = enb_c;
      fifo0_d     = fifo0_q;
      fifo1_d     = fifo1_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q + {1'b0, push} - {1'b0, pop};

      if (enb_c) begin
         iss_addr_d = iss_addr_q + 1'b1;
         iss_rem_d  = iss_rem_q - 1'b1;
      end
      if (push) begin
         if (wr_ptr_q) fifo1_d = dob;
         else          fifo0_d = dob;
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d   = ~rd_ptr_q;
         emit_rem_d = emit_rem_q - 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               iss_addr_d = base_addr;
               iss_rem_d  = len;
               emit_rem_d = len;
               state_d    = (len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (pop && out_last) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         iss_addr_q  <= '0;
         addr_hold_q <= '0;
         iss_rem_q   <= '0;
         emit_rem_q  <= '0;
         inflight_q  <= 1'b0;
         fifo0_q     <= '0;
         fifo1_q     <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
      end else begin
         state_q     <= state_d;
         iss_addr_q  <= iss_addr_d;
         addr_hold_q <= addr_hold_d;
         iss_rem_q   <= iss_rem_d;
         emit_rem_q  <= emit_rem_d;
         inflight_q  <= inflight_d;
         fifo0_q     <= fifo0_d;
         fifo1_q     <= fifo1_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: a RAM model, a queue-based reference of the expected stream,
// and one negedge compare process; directed scenarios pin the model with literal expectations.
module tb_bram_stream_reader;
   localparam int AW    = 8;
   localparam int DW    = 16;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   len = '0;
   logic          out_ready = 1'b1;
   logic [DW-1:0] dob = '0;
   logic          busy, done, enb, out_valid, out_last;
   logic [AW-1:0] addrb;
   logic [DW-1:0] out_data;

   logic [DW-1:0] mem [DEPTH];

   bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy), .done(done), .enb(enb), .addrb(addrb), .dob(dob),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (enb) dob <= mem[addrb];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // reference model state
   typedef struct { logic [DW-1:0] d; bit last; } word_t;
   word_t         word_q[$];
   logic [AW-1:0] addr_q[$];
   bit            m_busy = 0, m_done = 0, busy_now, done_now, last_hs;
   int            issued = 0, hs_cnt = 0, cyc = 0, start_cyc = 0, done_cyc = -1;
   logic [AW-1:0] last_addr = '0, a_tmp;
   bit            stall_prev = 0, prev_l;
   logic [DW-1:0] prev_d;
   logic [DW-1:0] hs_data[$];
   bit            hs_last[$];
   int            hs_cyc[$];
   logic [AW-1:0] iss_addr[$];
   int            iss_cyc[$];
   int            ready_mode = 0;
   bit            ready_tog = 1'b1;

   always @(posedge clk) cyc++;

   always begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: begin ready_tog = ~ready_tog; out_ready = ready_tog; end
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin
      if (rst) begin
         word_q.delete(); addr_q.delete();
         m_busy = 0; m_done = 0; issued = 0; hs_cnt = 0;
         last_addr = '0; stall_prev = 0;
      end else begin
         busy_now = m_busy;
         done_now = m_done;
         last_hs  = 0;
         chk(busy == busy_now, "busy", busy, busy_now);
         chk(done == done_now, "done", done, done_now);
         if (done) done_cyc = cyc;
         if (enb) begin
            chk(busy_now, "enb_outside_run", enb, 0);
            if (addr_q.size() == 0) chk(0, "enb_extra_issue", addrb, 0);
            else begin
               chk(addrb == addr_q[0], "addrb", addrb, addr_q[0]);
               void'(addr_q.pop_front());
            end
            issued++;
            last_addr = addrb;
            iss_addr.push_back(addrb);
            iss_cyc.push_back(cyc);
         end else begin
            chk(addrb == last_addr, "addrb_hold", addrb, last_addr);
         end
         if (!busy_now) chk(!out_valid, "valid_outside_run", out_valid, 0);
         if (stall_prev)
            chk(out_valid && out_data == prev_d && out_last == prev_l, "stall_hold", out_data, prev_d);
         if (out_valid) begin
            if (word_q.size() == 0) chk(0, "valid_no_word", out_data, 0);
            else begin
               chk(out_data == word_q[0].d, "out_data", out_data, word_q[0].d);
               chk(out_last == word_q[0].last, "out_last", out_last, word_q[0].last);
               if (out_ready) begin
                  hs_data.push_back(out_data);
                  hs_last.push_back(out_last);
                  hs_cyc.push_back(cyc);
                  if (word_q[0].last) last_hs = 1;
                  void'(word_q.pop_front());
                  hs_cnt++;
               end
            end
         end
         stall_prev = out_valid && !out_ready;
         prev_d = out_data;
         prev_l = out_last;
         chk(issued - hs_cnt <= 2, "occupancy", issued - hs_cnt, 2);

         m_done = 0;
         if (last_hs) begin m_busy = 0; m_done = 1; end
         if (start && !busy_now && !done_now) begin
            start_cyc = cyc; done_cyc = -1; issued = 0; hs_cnt = 0;
            hs_data.delete(); hs_last.delete(); hs_cyc.delete();
            iss_addr.delete(); iss_cyc.delete();
            if (len == 0) m_done = 1;
            else begin
               m_busy = 1;
               for (int i = 0; i < int'(len); i++) begin
                  a_tmp = base_addr + AW'(i);
                  addr_q.push_back(a_tmp);
                  word_q.push_back('{d: mem[a_tmp], last: (i == int'(len) - 1)});
               end
            end
         end
      end
   end

   task automatic pulse_start(input logic [AW-1:0] b, input int l);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; len = l[AW:0];
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((m_busy || m_done) && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk(k < budget, "idle_timeout", k, budget);
      @(posedge clk); #1;
   endtask

   task automatic run_cmd(input logic [AW-1:0] b, input int l, input int mode, input int budget);
      ready_mode = mode;
      pulse_start(b, l);
      wait_idle(budget);
   endtask

   task automatic check_zero_outputs();
      chk(busy == 0, "rst_busy", busy, 0);
      chk(done == 0, "rst_done", done, 0);
      chk(enb == 0, "rst_enb", enb, 0);
      chk(addrb == 0, "rst_addrb", addrb, 0);
      chk(out_valid == 0, "rst_valid", out_valid, 0);
      chk(out_data == 0, "rst_data", out_data, 0);
      chk(out_last == 0, "rst_last", out_last, 0);
   endtask

   initial begin
      int k;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(3 * i);
      #1 rst = 1'b1;
      #2 check_zero_outputs();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // basic stream with literal timing and data
      run_cmd(8'h10, 4, 0, 50);
      chk(hs_data.size() == 4, "basic_count", hs_data.size(), 4);
      for (int i = 0; i < 4 && i < hs_data.size(); i++) begin
         chk(hs_data[i] == DW'(16'h30 + 3 * i), "basic_data", hs_data[i], 16'h30 + 3 * i);
         chk(hs_last[i] == (i == 3), "basic_last", hs_last[i], i == 3);
         chk(hs_cyc[i] == start_cyc + i + 3, "basic_hs_cycle", hs_cyc[i] - start_cyc, i + 3);
      end
      chk(iss_addr.size() == 4, "basic_issues", iss_addr.size(), 4);
      for (int i = 0; i < 4 && i < iss_addr.size(); i++) begin
         chk(iss_addr[i] == AW'(8'h10 + i), "basic_addr", iss_addr[i], 8'h10 + i);
         chk(iss_cyc[i] == start_cyc + 1 + i, "basic_issue_cycle", iss_cyc[i] - start_cyc, 1 + i);
      end
      chk(done_cyc == start_cyc + 7, "basic_done_cycle", done_cyc - start_cyc, 7);

      // address wrap
      run_cmd(8'hFE, 4, 0, 50);
      chk(iss_addr.size() == 4, "wrap_issues", iss_addr.size(), 4);
      if (iss_addr.size() == 4) begin
         chk(iss_addr[0] == 8'hFE && iss_addr[1] == 8'hFF && iss_addr[2] == 8'h00 && iss_addr[3] == 8'h01,
             "wrap_addr_seq", {iss_addr[0], iss_addr[1], iss_addr[2], iss_addr[3]}, 32'hFEFF0001);
      end
      chk(hs_data.size() == 4, "wrap_count", hs_data.size(), 4);
      if (hs_data.size() == 4) begin
         chk(hs_data[0] == 16'h02FA && hs_data[1] == 16'h02FD && hs_data[2] == 16'h0000 && hs_data[3] == 16'h0003,
             "wrap_data_seq", {hs_data[0], hs_data[1], hs_data[2], hs_data[3]}, 64'h02FA02FD00000003);
      end

      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);

      // backpressure: alternating then random ready
      run_cmd(8'h33, 8, 1, 100);
      chk(hs_data.size() == 8, "bp_alt_count", hs_data.size(), 8);
      run_cmd(AW'($urandom), 8, 2, 200);
      chk(hs_data.size() == 8, "bp_rand_count", hs_data.size(), 8);

      // zero length
      run_cmd(8'h55, 0, 0, 20);
      chk(iss_addr.size() == 0, "len0_no_enb", iss_addr.size(), 0);
      chk(hs_data.size() == 0, "len0_no_data", hs_data.size(), 0);
      chk(done_cyc == start_cyc + 1, "len0_done_cycle", done_cyc - start_cyc, 1);

      // start during RUN is ignored
      ready_mode = 0;
      pulse_start(8'h20, 6);
      repeat (2) @(posedge clk);
      #1 start = 1'b1; base_addr = 8'h80; len = 9'd3;
      @(posedge clk); #1 start = 1'b0;
      wait_idle(60);
      chk(hs_data.size() == 6, "ignore_start_count", hs_data.size(), 6);
      for (int i = 0; i < 6 && i < hs_data.size(); i++)
         chk(hs_data[i] == mem[8'h20 + i], "ignore_start_data", hs_data[i], mem[8'h20 + i]);

      // full depth
      run_cmd(8'h00, 256, 0, 400);
      chk(hs_data.size() == 256, "full_count", hs_data.size(), 256);
      chk(iss_addr.size() == 256 && iss_addr[255] == 8'hFF, "full_last_addr", last_addr, 8'hFF);
      chk(hs_last.size() == 256 && hs_last[255] && !hs_last[254], "full_last_flag", hs_last.size(), 256);

      // reset mid-transfer
      ready_mode = 0;
      pulse_start(8'hA0, 10);
      k = 0;
      while (hs_cnt < 3 && k < 100) begin
         @(posedge clk);
         k++;
      end
      chk(k < 100, "rst_wait_timeout", k, 100);
      #2 rst = 1'b1;
      #1 check_zero_outputs();
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      run_cmd(8'h40, 2, 0, 40);
      chk(hs_data.size() == 2, "post_rst_count", hs_data.size(), 2);
      if (hs_data.size() == 2) begin
         chk(hs_data[0] == mem[8'h40], "post_rst_word0", hs_data[0], mem[8'h40]);
         chk(hs_data[1] == mem[8'h41], "post_rst_word1", hs_data[1], mem[8'h41]);
      end

      // random commands
      for (int n = 0; n < 8; n++) begin
         int l;
         l = $urandom_range(1, 20);
         run_cmd(AW'($urandom), l, $urandom_range(0, 2), 200);
         chk(hs_data.size() == l, "rand_count", hs_data.size(), l);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got %0d, expected 0", 1);
      $fatal(1, "timeout");
   end
endmodule
